// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus the stage's
// flush and occupancy sideband.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 35,
  parameter int CTRL_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a one-entry skid buffer so in_ready comes
// straight from a flop; an empty stage always presents zeroed control (bubble).
module pipe_stage_skid #(
  parameter int DATA_W = 35,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] m_data_r;
  logic [DATA_W-1:0] s_data_r;
  logic [CTRL_W-1:0] s_ctrl_r;
  // Main control is kept pre-masked, so it reads zero whenever the stage is empty.
  logic [CTRL_W-1:0] out_ctrl_r;
  logic              out_valid_r;
  logic              in_ready_r;
  logic [1:0]        occupancy_r;
  logic              accept_s;
  logic              consume_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign consume_s = out_valid_r & bus.out_ready;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = m_data_r;
  assign bus.out_ctrl  = out_ctrl_r;
  assign bus.occupancy = occupancy_r;

  // Stage state machine: occupancy transitions, payload moves and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      m_data_r    <= '0;
      s_data_r    <= '0;
      s_ctrl_r    <= '0;
      out_ctrl_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
    end else if (bus.flush) begin
      // A same-cycle consume has already been sampled downstream; the accept is dropped.
      state_r     <= EMPTY;
      out_ctrl_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            m_data_r    <= bus.in_data;
            out_ctrl_r  <= bus.in_ctrl;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            m_data_r   <= bus.in_data;
            out_ctrl_r <= bus.in_ctrl;
          end else if (accept_s) begin
            s_data_r    <= bus.in_data;
            s_ctrl_r    <= bus.in_ctrl;
            in_ready_r  <= 1'b0;
            occupancy_r <= 2'd2;
            state_r     <= FULL;
          end else if (consume_s) begin
            out_ctrl_r  <= '0;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
            state_r     <= EMPTY;
          end
        end
        FULL: begin
          if (consume_s) begin
            m_data_r    <= s_data_r;
            out_ctrl_r  <= s_ctrl_r;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd1;
            state_r     <= ONE;
          end
        end
        default: begin
          out_ctrl_r  <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          occupancy_r <= 2'd0;
          state_r     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, bubble insertion and synchronous flush. It is the next-generation replacement for the fixed-width inter-stage flop banks, starting with EX/MEM, so that MEM can stall on a slow memory without a combinational ready path back into EX. Datapath and control fields are carried as two separately parametrised vectors. Control bits are forced to zero whenever the stage holds no valid instruction, so an empty stage is always a bubble.

## Interface
Parameters:
- DATA_W, 35: width of datapath payload (e.g. instruction, ALU result, store data, register IDs).
- CTRL_W, 11: width of control payload (e.g. Dst_reg, PC_src, Reg_write, Mem_read, Mem_write, Mem_reg, Mem_en, halt).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage presents a valid instruction.
- in_ready  out  1  stage can accept this cycle; driven directly from a flop.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  main entry is valid.
- out_ready  in  1  downstream consumes the main entry this cycle.
- out_data  out  DATA_W  main-entry datapath payload.
- out_ctrl  out  CTRL_W  main-entry control payload; all zeros when out_valid=0.
- occupancy  out  2  number of held entries (0, 1 or 2).

## Operation
Storage:
- Main register (m_valid, m_data, m_ctrl).
- Skid register (s_valid, s_data, s_ctrl).

Handshake:
- accept = in_valid & in_ready.
- consume = out_valid & out_ready.

Outputs:
- in_ready = ~s_valid.
- out_valid = m_valid.
- out_ctrl = m_valid ? m_ctrl : 0.
- occupancy = m_valid + s_valid.

States:
- EMPTY (m=0, s=0).
- ONE (m=1, s=0).
- FULL (m=1, s=1).
- s_valid=1 with m_valid=0 is illegal and never reached.

Transitions (flush=0, rst=0):
- EMPTY: accept → ONE with main ← in.
- ONE: accept & consume → ONE with main ← in. Accept & ~consume → FULL with skid ← in. ~accept & consume → EMPTY. Otherwise hold.
- FULL: in_ready=0, so no accept. Consume → ONE with main ← skid and skid cleared. Otherwise hold.

Flush:
- m_valid and s_valid are cleared on the next edge, whatever the state.
- An accept in the same cycle is discarded.
- A consume in the same cycle still completes, because downstream has already sampled the entry.
- Next state is EMPTY, with in_ready=1.

Reset:
- rst has priority over flush and over all handshakes.
- One cycle of rst from any state, including FULL mid-stall, gives EMPTY.

Payload rules:
- Payload registers load only on the transitions listed above; otherwise they hold.
- When m_valid=0, out_data holds its last value and must not be relied on.
- Payload is passed through bit-exact, with no arithmetic.

## Timing
Reset values, on the edge after rst=1:
- m_valid=0, s_valid=0.
- m_data, s_data, m_ctrl, s_ctrl all 0.
- out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.

Latency and throughput:
- Accept at edge N gives out_valid=1 with that payload after edge N; minimum latency is one cycle.
- Sustained throughput is one entry per cycle while out_ready=1.

Ready paths:
- in_ready depends only on s_valid, so there is no combinational path from out_ready to in_ready.
- When out_ready deasserts, exactly one more entry is absorbed, into the skid register.
- in_ready drops on the cycle after that absorption.
- When out_ready reasserts, the skid entry moves to main on the first consume, and in_ready returns to 1 the cycle after that.

Ordering:
- Entries leave in strict acceptance order.
- No entry is duplicated or dropped, except by flush or rst.

## Test plan
- Reset check: assert rst with the stage FULL (payloads 0x1AAA then 0x1BBB) → next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on the following consecutive cycles, out_valid continuous, occupancy=1 throughout.
- Stall and skid: stream 5,6,7 and drop out_ready in the cycle 5 is presented → 6 goes to skid, in_ready=0, 7 is held upstream. Raise out_ready → outputs 5,6,7 in order with no loss.
- Bubble: in_valid=0 while in_ctrl=0x7FF → out_valid=0 and out_ctrl=0x000 every cycle.
- Flush: flush=1 in FULL with in_valid=1 and data 9 → next cycle occupancy=0; value 9 never appears on out_data.
- Random soak: random in_valid, out_ready and flush (flush 5%) for 10k cycles, checked against a scoreboard → order preserved, occupancy never exceeds 2, and out_ctrl=0 whenever out_valid=0.
